int_to_fp_encoder: RTL and testbench

- Iterative converter from a signed 32-bit two's-complement integer to the team's 32-bit float format.
- Float format: sign [31], exponent [30:21] biased by EXP_BIAS, mantissa [20:0] with hidden leading 1.
- Produces operands for the FPU adder, so it is the encoding end of the format that the adder decodes.
- Normalises one bit per clock, truncates toward zero, and reports status using the same four-code status encoding as the FPU.

---
 rtl/int_to_fp_encoder.sv | 93 +++++++++
 tb/tb_int_to_fp_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/int_to_fp_encoder.sv
// Iterative signed 32-bit integer to float encoder: {sign, exp[9:0], mant[20:0]}.
// Normalises one bit per clock and truncates the mantissa toward zero.
module int_to_fp_encoder #(
  parameter int EXP_BIAS = 511
) (
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic [31:0] int_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  localparam logic [3:0] STATUS_OVERFLOW  = 4'd0;
  localparam logic [3:0] STATUS_UNDERFLOW = 4'd1;
  localparam logic [3:0] STATUS_EXACT     = 4'd2;
  localparam logic [3:0] STATUS_INEXACT   = 4'd3;

  typedef enum logic [1:0] {IDLE, ABS, NORMALIZE, PACK} state_t;

  state_t      state;
  logic [31:0] int_reg;
  logic [31:0] mag;
  logic        sign;
  logic [4:0]  count;
  logic [31:0] abs_val;
  logic [9:0]  exp_val;

  // Overflow/underflow cannot occur for any 32-bit input with the default bias;
  // the codes exist only so the encoding matches the FPU status field.
  logic unused_codes;
  assign unused_codes = ^{STATUS_OVERFLOW, STATUS_UNDERFLOW};

  always_comb begin
    abs_val = int_reg[31] ? (~int_reg + 32'd1) : int_reg;
    exp_val = 10'(EXP_BIAS) + 10'd31 - {5'd0, count};
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      int_reg    <= 32'd0;
      mag        <= 32'd0;
      sign       <= 1'b0;
      count      <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= 32'd0;
      status_out <= STATUS_EXACT;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            int_reg <= int_in;
            busy    <= 1'b1;
            state   <= ABS;
          end
        end
        ABS: begin
          sign  <= int_reg[31];
          mag   <= abs_val;
          count <= 5'd0;
          state <= (abs_val == 32'd0) ? PACK : NORMALIZE;
        end
        NORMALIZE: begin
          if (mag[31]) begin
            state <= PACK;
          end else begin
            mag   <= mag << 1;
            count <= count + 5'd1;
          end
        end
        PACK: begin
          if (mag == 32'd0) begin
            data_out   <= 32'd0;
            status_out <= STATUS_EXACT;
          end else begin
            data_out   <= {sign, exp_val, mag[30:10]};
            status_out <= (mag[9:0] != 10'd0) ? STATUS_INEXACT : STATUS_EXACT;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_encoder.sv
// Directed bench for int_to_fp_encoder: vector table plus control-path sequences.
// Latency counts edges inclusively, the accepting edge being edge 1.
module tb_int_to_fp_encoder;

  logic        clock_100Khz = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] int_in = 32'd0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int total = 0;
  int bad = 0;

  int_to_fp_encoder #(.EXP_BIAS(511)) dut (
    .clock_100Khz(clock_100Khz),
    .reset(reset),
    .int_in(int_in),
    .start(start),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .status_out(status_out)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  typedef struct {
    logic [31:0] value;
    logic [31:0] exp_data;
    logic [3:0]  exp_status;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after the accepting edge; returns inclusive edge count to done.
  task automatic waitDone(output int lat, output logic busy_ok);
    lat = 1;
    busy_ok = busy;
    while (!done && lat < 60) begin
      @(posedge clock_100Khz);
      #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    if (done && busy) busy_ok = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] value, output int lat, output logic busy_ok);
    @(negedge clock_100Khz);
    int_in = value;
    start  = 1'b1;
    @(posedge clock_100Khz);
    #1;
    start  = 1'b0;
    int_in = ~value;
    waitDone(lat, busy_ok);
  endtask

  task automatic watchNoDone(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clock_100Khz);
      #1;
      if (done) seen = 1'b1;
    end
    checkOutput(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic busy_ok;

    vecs[0] = '{32'h0000_0001, 32'h3FE0_0000, 4'd2, 35};
    vecs[1] = '{32'hFFFF_FFFF, 32'hBFE0_0000, 4'd2, 35};
    vecs[2] = '{32'h0000_0003, 32'h4010_0000, 4'd2, 34};
    vecs[3] = '{32'h7FFF_FFFF, 32'h43BF_FFFF, 4'd3, 5};
    vecs[4] = '{32'h8000_0000, 32'hC3C0_0000, 4'd2, 4};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 4'd2, 3};

    #12;
    checkOutput("reset_data", data_out, 32'd0);
    checkOutput("reset_status", {28'd0, status_out}, 32'd2);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    @(negedge clock_100Khz);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].value, lat, busy_ok);
      checkOutput($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_status", i), {28'd0, status_out}, {28'd0, vecs[i].exp_status});
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
      @(posedge clock_100Khz);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      checkOutput($sformatf("vec%0d_hold", i), data_out, vecs[i].exp_data);
    end

    // A start while busy must neither restart nor queue a second conversion.
    @(negedge clock_100Khz);
    int_in = 32'h0000_0001;
    start  = 1'b1;
    @(posedge clock_100Khz);
    #1;
    start = 1'b0;
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock_100Khz);
      #1;
      lat++;
    end
    int_in = 32'h0000_0000;
    start  = 1'b1;
    @(posedge clock_100Khz);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 60) begin
      @(posedge clock_100Khz);
      #1;
      lat++;
    end
    checkOutput("busy_start_latency", lat, 35);
    checkOutput("busy_start_data", data_out, 32'h3FE0_0000);
    watchNoDone("busy_start_no_extra_done", 40);

    // Reset during NORMALIZE aborts immediately with no done.
    applyStimulus(32'h7FFF_FFFF, lat, busy_ok);
    checkOutput("pre_abort_data", data_out, 32'h43BF_FFFF);
    @(negedge clock_100Khz);
    int_in = 32'h0000_0001;
    start  = 1'b1;
    @(posedge clock_100Khz);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clock_100Khz);
    @(negedge clock_100Khz);
    reset = 1'b0;
    #1;
    checkOutput("abort_data", data_out, 32'd0);
    checkOutput("abort_status", {28'd0, status_out}, 32'd2);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    @(negedge clock_100Khz);
    reset = 1'b1;
    watchNoDone("abort_no_done", 40);

    // Start raised during the done cycle is accepted on the next edge.
    applyStimulus(32'h8000_0000, lat, busy_ok);
    checkOutput("b2b_first_data", data_out, 32'hC3C0_0000);
    checkOutput("b2b_first_latency", lat, 4);
    int_in = 32'h0000_0003;
    start  = 1'b1;
    @(posedge clock_100Khz);
    #1;
    start  = 1'b0;
    int_in = 32'hDEAD_BEEF;
    checkOutput("b2b_done_dropped", {31'd0, done}, 32'd0);
    waitDone(lat, busy_ok);
    checkOutput("b2b_second_data", data_out, 32'h4010_0000);
    checkOutput("b2b_second_status", {28'd0, status_out}, 32'd2);
    checkOutput("b2b_second_latency", lat, 34);
    checkOutput("b2b_second_busy", {31'd0, busy_ok}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
